cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
//  Run-control block in front of the single-cycle CPU core.
//  - Holds the core in reset, then releases it.
//  - Gates the core with a clock enable for a programmable cycle budget, or free-run, or single-step.
//  - Stops on halt, budget expiry or an external stop, and reports the cause and the executed cycle count.
//  - Replaces fixed "toggle N clocks, then finish" sequencing with a synthesizable, reusable controller.
// PARAMETERS
//  CNT_W      16  width of the cycle budget and cycle counter
//  RST_CYC    4   number of Clock cycles CpuRstN is held low after Start (>=1)
//  PC_W       16  width of the PC / breakpoint compare (used only with BREAKPOINT_EN)
// PORTS
//  Clock      in   1      single system clock, rising edge
//  ResetN     in   1      asynchronous, active-low reset
//  Start      in   1      1-cycle pulse: begin a run (accepted in IDLE/DONE only)
//  Stop       in   1      level: request stop while running
//  StepMode   in   1      1 = single-step, sampled each cycle in RUN
//  Step       in   1      1-cycle pulse: grant one core cycle when StepMode=1
//  Budget     in   CNT_W  cycle budget, latched on accepted Start; 0 = unlimited
//  Halt       in   1      core halt indication, sampled only on enabled cycles
//  CpuRstN    out  1      active-low reset to the core
//  CpuEn      out  1      clock enable to the core: one core cycle per Clock with CpuEn=1
//  Running    out  1      1 in RESET_CPU or RUN
//  Done       out  1      1 in DONE
//  DoneCause  out  2      00 none, 01 budget, 10 halt, 11 stop/breakpoint
//  CycleCount out  CNT_W  number of CpuEn=1 cycles in the current run, saturating
// BEHAVIOUR
//  - Reset (ResetN=0, asynchronous, any state):
//    - state=IDLE, CpuRstN=0, CpuEn=0, Running=0, Done=0, DoneCause=00, CycleCount=0.
//  - States and transitions:
//    - IDLE: CpuRstN=0. Start -> RESET_CPU. Budget is latched and CycleCount cleared.
//    - RESET_CPU: CpuRstN=0 for exactly RST_CYC cycles, then -> RUN with CpuRstN=1.
//    - RUN: CpuEn = StepMode ? Step : 1 (combinational from registered state; Step pulse gives exactly 1 enabled cycle).
//      - Each CpuEn=1 cycle increments CycleCount; it saturates at all-ones.
//      - Exit at the clock edge ending a cycle that meets a stop condition. Priority when several coincide: Halt > budget > Stop.
//        - Halt=1 on an enabled cycle -> DONE, cause 10; that cycle is counted.
//        - Budget!=0 and the enabled cycle makes CycleCount==Budget -> DONE, cause 01. Exactly Budget enabled cycles, no more.
//        - Stop=1 -> DONE, cause 11. If CpuEn=1 that cycle, it is counted.
//    - DONE: CpuEn=0, CpuRstN=1 (core state preserved for inspection), Done=1. DoneCause and CycleCount hold.
//      Start -> RESET_CPU: clears DoneCause and CycleCount, latches a new Budget.
//  - Start in RESET_CPU/RUN is ignored; Budget changes after Start have no effect.
//  - StepMode may toggle mid-run; it takes effect on the same cycle.
//  - Saturation with Budget=0 does not stop the run.
//  - All outputs registered except CpuEn. Start->first CpuEn=1 latency = RST_CYC+1 Clock cycles.
// CONFIGURATION
//  BREAKPOINT_EN defined:
//    - Adds ports Pc (in, PC_W), BreakAddr (in, PC_W), BreakArm (in, 1).
//    - In RUN, an enabled cycle with BreakArm=1 and Pc==BreakAddr -> DONE, cause 11.
//      That cycle is counted. Priority is below Halt and above budget.
//  BREAKPOINT_EN undefined: no extra ports or logic; behaviour as above.
// TESTING
//  1 Budget=60, Start, StepMode=0 -> CpuRstN low 4 cycles; then 60 consecutive CpuEn=1; Done=1, DoneCause=01, CycleCount=60.
//  2 Budget=0, Halt=1 on 17th enabled cycle -> DONE, cause 10, CycleCount=17, CpuEn=0 on next cycle.
//  3 StepMode=1, Budget=0, 3 Step pulses 5 cycles apart, then Stop -> exactly 3 CpuEn=1 cycles, CycleCount=3, cause 11.
//  4 Budget=10, Halt and 10th cycle coincide -> cause 10 (priority), CycleCount=10; restart with Start, Budget=5 -> count clears, cause 01 at 5.
//  5 ResetN low mid-RUN at count 25 -> all outputs to reset values asynchronously; Start after release runs cleanly from 0.
//  6 BREAKPOINT_EN: BreakArm=1, BreakAddr=0x0008, Pc=cycle index -> DONE at count 9, cause 11; BreakArm=0 -> budget stop.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run-control FSM in front of the single-cycle core: core reset sequencing, clock-enable gating, stop-cause reporting.
// Optional breakpoint compare is built when the BREAKPOINT_EN macro is defined.
module cpu_run_ctrl #(
  parameter int CNT_W   = 16,
  parameter int RST_CYC = 4
`ifdef BREAKPOINT_EN
  ,
  parameter int PC_W    = 16
`endif
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             Start,
  input  logic             Stop,
  input  logic             StepMode,
  input  logic             Step,
  input  logic [CNT_W-1:0] Budget,
  input  logic             Halt,
`ifdef BREAKPOINT_EN
  input  logic [PC_W-1:0]  Pc,
  input  logic [PC_W-1:0]  BreakAddr,
  input  logic             BreakArm,
`endif
  output logic             CpuRstN,
  output logic             CpuEn,
  output logic             Running,
  output logic             Done,
  output logic [1:0]       DoneCause,
  output logic [CNT_W-1:0] CycleCount
);

  localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYC - 1);

  typedef enum logic [1:0] {
    st_idle      = 2'b00,
    st_reset_cpu = 2'b01,
    st_run       = 2'b10,
    st_done      = 2'b11
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] budget_r;
  logic [CNT_W-1:0] budget_nxt_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic [CNT_W-1:0] count_inc_s;
  logic [1:0]       cause_nxt_s;
  logic [RW-1:0]    rst_cnt_r;
  logic [RW-1:0]    rst_cnt_nxt_s;
  logic             cpu_en_s;
  logic             bp_hit_s;
  logic             budget_hit_s;

  // Core enable is the only combinational output: it must follow Step/StepMode in the same cycle.
  assign cpu_en_s = (state_r == st_run) && (StepMode ? Step : 1'b1);
  assign CpuEn    = cpu_en_s;

`ifdef BREAKPOINT_EN
  assign bp_hit_s = cpu_en_s && BreakArm && (Pc == BreakAddr);
`else
  assign bp_hit_s = 1'b0;
`endif

  assign count_inc_s  = (CycleCount == {CNT_W{1'b1}}) ? CycleCount
                        : CycleCount + {{(CNT_W-1){1'b0}}, 1'b1};
  assign budget_hit_s = cpu_en_s && (budget_r != {CNT_W{1'b0}}) && (count_inc_s == budget_r);

  // Next-state, budget latch, cycle count and stop-cause selection.
  always_comb begin
    state_nxt_s   = state_r;
    budget_nxt_s  = budget_r;
    count_nxt_s   = CycleCount;
    cause_nxt_s   = DoneCause;
    rst_cnt_nxt_s = rst_cnt_r;
    case (state_r)
      st_idle, st_done: begin
        if (Start) begin
          state_nxt_s   = st_reset_cpu;
          budget_nxt_s  = Budget;
          count_nxt_s   = {CNT_W{1'b0}};
          cause_nxt_s   = 2'b00;
          rst_cnt_nxt_s = {RW{1'b0}};
        end else begin
          state_nxt_s   = state_r;
        end
      end
      st_reset_cpu: begin
        if (rst_cnt_r == RST_LAST) begin
          state_nxt_s   = st_run;
          rst_cnt_nxt_s = {RW{1'b0}};
        end else begin
          rst_cnt_nxt_s = rst_cnt_r + {{(RW-1){1'b0}}, 1'b1};
        end
      end
      st_run: begin
        if (cpu_en_s) begin
          count_nxt_s = count_inc_s;
        end else begin
          count_nxt_s = CycleCount;
        end
        // Halt outranks breakpoint, which outranks budget, which outranks Stop.
        if (cpu_en_s && Halt) begin
          state_nxt_s = st_done;
          cause_nxt_s = 2'b10;
        end else if (bp_hit_s) begin
          state_nxt_s = st_done;
          cause_nxt_s = 2'b11;
        end else if (budget_hit_s) begin
          state_nxt_s = st_done;
          cause_nxt_s = 2'b01;
        end else if (Stop) begin
          state_nxt_s = st_done;
          cause_nxt_s = 2'b11;
        end else begin
          state_nxt_s = st_run;
        end
      end
      default: begin
        state_nxt_s = st_idle;
      end
    endcase
  end

  // State and registered outputs; status flags are decoded from the next state so they align with it.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_r    <= st_idle;
      budget_r   <= {CNT_W{1'b0}};
      rst_cnt_r  <= {RW{1'b0}};
      CpuRstN    <= 1'b0;
      Running    <= 1'b0;
      Done       <= 1'b0;
      DoneCause  <= 2'b00;
      CycleCount <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      budget_r   <= budget_nxt_s;
      rst_cnt_r  <= rst_cnt_nxt_s;
      CpuRstN    <= (state_nxt_s == st_run) || (state_nxt_s == st_done);
      Running    <= (state_nxt_s == st_reset_cpu) || (state_nxt_s == st_run);
      Done       <= (state_nxt_s == st_done);
      DoneCause  <= cause_nxt_s;
      CycleCount <= count_nxt_s;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed self-checking bench for cpu_run_ctrl; inputs driven on the falling edge, outputs checked #1 later.
module tb_cpu_run_ctrl;
  localparam int CNT_W   = 16;
  localparam int RST_CYC = 4;

  logic             Clock = 1'b0;
  logic             ResetN, Start, Stop, StepMode, Step, Halt;
  logic [CNT_W-1:0] Budget;
  logic             CpuRstN, CpuEn, Running, Done;
  logic [1:0]       DoneCause;
  logic [CNT_W-1:0] CycleCount;
`ifdef BREAKPOINT_EN
  logic [15:0]      Pc, BreakAddr;
  logic             BreakArm;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  cpu_run_ctrl #(.CNT_W(CNT_W), .RST_CYC(RST_CYC)) dut (
    .Clock(Clock), .ResetN(ResetN), .Start(Start), .Stop(Stop),
    .StepMode(StepMode), .Step(Step), .Budget(Budget), .Halt(Halt),
`ifdef BREAKPOINT_EN
    .Pc(Pc), .BreakAddr(BreakAddr), .BreakArm(BreakArm),
`endif
    .CpuRstN(CpuRstN), .CpuEn(CpuEn), .Running(Running), .Done(Done),
    .DoneCause(DoneCause), .CycleCount(CycleCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_done(input string tag, input logic [1:0] cause, input logic [CNT_W-1:0] cnt);
    check({tag, "_done"},    32'(Done), 32'd1);
    check({tag, "_en"},      32'(CpuEn), 32'd0);
    check({tag, "_rstn"},    32'(CpuRstN), 32'd1);
    check({tag, "_running"}, 32'(Running), 32'd0);
    check({tag, "_cause"},   32'(DoneCause), 32'(cause));
    check({tag, "_count"},   32'(CycleCount), 32'(cnt));
  endtask

  // Called on a falling edge; returns on the falling edge of the first RUN cycle.
  task automatic start_run(input logic [CNT_W-1:0] b);
    Budget = b;
    Start  = 1'b1;
    @(negedge Clock);
    Start  = 1'b0;
    Budget = ~b;
    for (int i = 0; i < RST_CYC; i++) begin
      #1;
      check("rst_low", 32'(CpuRstN), 32'd0);
      check("rst_en", 32'(CpuEn), 32'd0);
      check("rst_running", 32'(Running), 32'd1);
      if (i == 0) begin
        check("start_clr_count", 32'(CycleCount), 32'd0);
        check("start_clr_cause", 32'(DoneCause), 32'd0);
        check("start_clr_done", 32'(Done), 32'd0);
      end
      @(negedge Clock);
    end
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, "_rstn"},    32'(CpuRstN), 32'd0);
    check({tag, "_en"},      32'(CpuEn), 32'd0);
    check({tag, "_running"}, 32'(Running), 32'd0);
    check({tag, "_done"},    32'(Done), 32'd0);
    check({tag, "_cause"},   32'(DoneCause), 32'd0);
    check({tag, "_count"},   32'(CycleCount), 32'd0);
  endtask

  initial begin
    ResetN = 1'b0; Start = 1'b0; Stop = 1'b0; StepMode = 1'b0; Step = 1'b0;
    Halt = 1'b0; Budget = 16'd0;
`ifdef BREAKPOINT_EN
    Pc = 16'd0; BreakAddr = 16'd0; BreakArm = 1'b0;
`endif
    repeat (2) @(negedge Clock);
    #1 reset_outputs("por");
    ResetN = 1'b1;
    repeat (2) @(negedge Clock);
    #1 reset_outputs("idle");

    // 1: budget of 60 in free-run
    start_run(16'd60);
    for (int k = 1; k <= 60; k++) begin
      #1;
      check("t1_en", 32'(CpuEn), 32'd1);
      check("t1_rstn", 32'(CpuRstN), 32'd1);
      @(negedge Clock);
    end
    #1 check_done("t1", 2'b01, 16'd60);

    // 2: halt on the 17th enabled cycle, unlimited budget
    start_run(16'd0);
    for (int k = 1; k <= 17; k++) begin
      Halt = (k == 17);
      #1 check("t2_en", 32'(CpuEn), 32'd1);
      @(negedge Clock);
    end
    Halt = 1'b0;
    #1 check_done("t2", 2'b10, 16'd17);

    // 3: single-step, three pulses five cycles apart, then Stop
    StepMode = 1'b1;
    start_run(16'd0);
    for (int c = 0; c < 15; c++) begin
      Step = ((c % 5) == 0);
      #1 check("t3_en", 32'(CpuEn), 32'(Step));
      @(negedge Clock);
    end
    Step = 1'b0;
    Stop = 1'b1;
    #1 check("t3_stop_en", 32'(CpuEn), 32'd0);
    @(negedge Clock);
    Stop = 1'b0;
    StepMode = 1'b0;
    #1 check_done("t3", 2'b11, 16'd3);

    // 4: halt coincides with budget; then restart with budget 5, ignoring a mid-run Start
    start_run(16'd10);
    for (int k = 1; k <= 10; k++) begin
      Halt = (k == 10);
      #1;
      @(negedge Clock);
    end
    Halt = 1'b0;
    #1 check_done("t4a", 2'b10, 16'd10);
    start_run(16'd5);
    for (int k = 1; k <= 5; k++) begin
      Start  = (k == 2);
      Budget = 16'd3;
      #1 check("t4b_en", 32'(CpuEn), 32'd1);
      @(negedge Clock);
    end
    Start = 1'b0;
    #1 check_done("t4b", 2'b01, 16'd5);

    // 5: asynchronous reset mid-run, then a clean run
    start_run(16'd0);
    repeat (25) @(negedge Clock);
    #1 check("t5_count25", 32'(CycleCount), 32'd25);
    ResetN = 1'b0;
    #1 reset_outputs("t5_async");
    @(negedge Clock);
    ResetN = 1'b1;
    @(negedge Clock);
    start_run(16'd3);
    repeat (3) @(negedge Clock);
    #1 check_done("t5", 2'b01, 16'd3);

    // 6: budget beats Stop; Stop before budget; StepMode toggled mid-run
    start_run(16'd4);
    for (int k = 1; k <= 4; k++) begin
      Stop = (k == 4);
      #1;
      @(negedge Clock);
    end
    Stop = 1'b0;
    #1 check_done("t6a", 2'b01, 16'd4);
    start_run(16'd10);
    for (int k = 1; k <= 3; k++) begin
      Stop = (k == 3);
      #1;
      @(negedge Clock);
    end
    Stop = 1'b0;
    #1 check_done("t6b", 2'b11, 16'd3);
    start_run(16'd0);
    StepMode = 1'b1;
    #1 check("t6c_step_off", 32'(CpuEn), 32'd0);
    @(negedge Clock);
    StepMode = 1'b0;
    #1 check("t6c_free_on", 32'(CpuEn), 32'd1);
    @(negedge Clock);
    StepMode = 1'b1;
    Stop = 1'b1;
    #1;
    @(negedge Clock);
    Stop = 1'b0;
    StepMode = 1'b0;
    #1 check_done("t6c", 2'b11, 16'd1);

`ifdef BREAKPOINT_EN
    // 7: breakpoint at 0x0008 with Pc tracking the cycle index, then disarmed
    BreakArm = 1'b1;
    BreakAddr = 16'h0008;
    start_run(16'd0);
    for (int k = 1; k <= 9; k++) begin
      Pc = 16'(k - 1);
      #1;
      @(negedge Clock);
    end
    #1 check_done("t7a", 2'b11, 16'd9);
    BreakArm = 1'b0;
    start_run(16'd12);
    for (int k = 1; k <= 12; k++) begin
      Pc = 16'(k - 1);
      #1;
      @(negedge Clock);
    end
    #1 check_done("t7b", 2'b01, 16'd12);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
